wb_bus_arbiter: RTL
===================

// Module: wb_bus_arbiter
// PURPOSE
//  Two-master/one-slave Wishbone B3 classic arbiter. It shares one slave port,
//  such as the boot ROM or a shared RAM, between proc0IBus (master 0) and
//  proc0DBus (master 1). It replaces a directConnect where both buses must
//  reach the same slave. Grant is registered and round-robin, and is held for
//  the whole CYC burst. Responses are routed only to the granted master.
// PARAMETERS
//  ADR_W           32   address width, all ports
//  DAT_W           32   data width; SEL width = DAT_W/8
//  TIMEOUT_CYCLES  255  stall cycles before forced err (WB_ARB_TIMEOUT_EN only)
// PORTS
//  clock        in   1      bus clock (bClock)
//  reset        in   1      synchronous, active-low
//  mN_cyc_i     in   1      master N cycle (N=0,1)
//  mN_stb_i     in   1      master N strobe
//  mN_we_i      in   1      master N write enable
//  mN_sel_i     in   DAT/8  master N byte selects
//  mN_adr_i     in   ADR_W  master N address
//  mN_dat_i     in   DAT_W  master N write data
//  mN_dat_o     out  DAT_W  slave read data (same value to both masters)
//  mN_ack_o     out  1      ack to master N; 0 unless granted
//  mN_err_o     out  1      err to master N; 0 unless granted
//  mN_rty_o     out  1      rty to master N; 0 unless granted
//  s_cyc_o, s_stb_o, s_we_o  out  1    slave control
//  s_sel_o/s_adr_o/s_dat_o   out  DAT/8, ADR_W, DAT_W  slave request
//  s_dat_i, s_ack_i, s_err_i, s_rty_i  in  DAT_W, 1, 1, 1  slave response
// BEHAVIOUR
//  - FSM states: IDLE, GNT0, GNT1. Register last_gnt: 0 = m0 served last.
//  - IDLE -> GNT0 if m0_cyc & (~m1_cyc | last_gnt==1).
//  - IDLE -> GNT1 if m1_cyc & (~m0_cyc | last_gnt==0).
//  - Arbitration latency: 1 clock from CYC rising to slave s_cyc_o.
//  - GNTn -> IDLE on the first clock where mn_cyc_i==0. last_gnt<=n.
//  - There is one idle cycle between bursts. A master is never preempted
//    while its CYC is high.
//  - Slave request = registered-grant mux of the granted master's signals.
//    In IDLE: s_cyc/s_stb/s_we=0, s_sel/s_adr/s_dat=0.
//  - Response paths are combinational, zero added latency:
//    mn_ack/err/rty = s_* & (state==GNTn).
//  - Reset (reset==0 at a clock edge):
//    - state<=IDLE and last_gnt<=1, so m0 wins the first tie.
//    - All s_* request outputs and mN_ack/err/rty are 0 from that edge.
//    - Reset mid-burst aborts the burst. Any ack arriving after it is dropped.
//  - Simultaneous CYC in IDLE: the master not served last wins.
//    Lone requester: served regardless of last_gnt.
//  - A granted master dropping STB but holding CYC keeps the grant (lock).
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//   - A stall counter counts clocks with s_stb_o & ~(s_ack|s_err|s_rty).
//     It clears on any response or on leaving GNTn.
//   - At count == TIMEOUT_CYCLES-1 the next clock does three things:
//     mn_err_o=1 for 1 clock, s_stb_o/s_cyc_o forced 0, counter cleared.
//   - The grant is kept until the master drops CYC.
//  WB_ARB_TIMEOUT_EN undefined:
//   - No counter. The arbiter waits indefinitely for the slave response.
// TESTING
//  1 Reset release, m0_cyc/stb rise at t0 -> s_cyc=1 at t0+1 with m0 adr;
//    slave ack at t0+2 -> m0_ack=1 at t0+2, m1_ack=0.
//  2 m0 and m1 raise CYC on the same clock after reset -> GNT0 first.
//    m0 drops CYC -> IDLE for 1 clock, then GNT1.
//  3 m1 burst of 4 acks with CYC held, m0 requesting throughout ->
//    no switch until m1_cyc=0.
//  4 reset=0 mid-burst, slave acks 1 clock later -> s_cyc=0, m*_ack=0,
//    state IDLE, next tie goes to m0.
//  5 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never responds ->
//    m0_err=1 exactly once, 8 clocks after s_stb rose.
//  6 Read 32'h11335577 from the slave via m1 -> m1_dat_o=32'h11335577,
//    m1_ack=1, m0_ack=0 on that cycle.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master / one-slave Wishbone B3 classic arbiter.
// Round-robin grant is registered and held for the whole CYC burst.
// The request is muxed from the granted master and responses are routed
// back to that master only, both combinationally.
// Optional feature macro: WB_ARB_TIMEOUT_EN adds a slave stall timeout that
// answers a hung access with a one-clock err and drops the slave cycle.
//
// state | meaning
// IDLE  | no grant, slave request outputs all zero
// GNT0  | master 0 owns the slave until m0_cyc_i falls
// GNT1  | master 1 owns the slave until m1_cyc_i falls

module wb_bus_arbiter #(
    parameter int ADR_W          = 32,
    parameter int DAT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               m0_cyc_i,
    input  logic               m0_stb_i,
    input  logic               m0_we_i,
    input  logic [DAT_W/8-1:0] m0_sel_i,
    input  logic [ADR_W-1:0]   m0_adr_i,
    input  logic [DAT_W-1:0]   m0_dat_i,
    output logic [DAT_W-1:0]   m0_dat_o,
    output logic               m0_ack_o,
    output logic               m0_err_o,
    output logic               m0_rty_o,

    input  logic               m1_cyc_i,
    input  logic               m1_stb_i,
    input  logic               m1_we_i,
    input  logic [DAT_W/8-1:0] m1_sel_i,
    input  logic [ADR_W-1:0]   m1_adr_i,
    input  logic [DAT_W-1:0]   m1_dat_i,
    output logic [DAT_W-1:0]   m1_dat_o,
    output logic               m1_ack_o,
    output logic               m1_err_o,
    output logic               m1_rty_o,

    output logic               s_cyc_o,
    output logic               s_stb_o,
    output logic               s_we_o,
    output logic [DAT_W/8-1:0] s_sel_o,
    output logic [ADR_W-1:0]   s_adr_o,
    output logic [DAT_W-1:0]   s_dat_o,
    input  logic [DAT_W-1:0]   s_dat_i,
    input  logic               s_ack_i,
    input  logic               s_err_i,
    input  logic               s_rty_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_gnt_q, last_gnt_d;   // 0: master 0 was served last

    // A one-clock err pulse and the hold that keeps the slave cycle dropped
    // until the timed-out master releases CYC.
    logic   tmo_pulse;
    logic   tmo_hold;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wb_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    // State and round-robin history register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Next-state: tie goes to the master not served last, grant held until CYC drops.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_gnt_q)) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b0;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_d    = IDLE;
                    last_gnt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_left;
    logic             granted;
    logic             leaving;
    logic             slave_resp;
    logic             stall;

    assign granted    = (state_q != IDLE);
    assign leaving    = granted && (state_d == IDLE);
    assign slave_resp = s_ack_i | s_err_i | s_rty_i;
    assign stall      = s_stb_o & ~slave_resp;

    // Stall timer: down-counts stalled strobes, fires when it hits zero on a stall.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tmo_left  <= TMO_LOAD;
            tmo_pulse <= 1'b0;
            tmo_hold  <= 1'b0;
        end else if (!granted || leaving) begin
            tmo_left  <= TMO_LOAD;
            tmo_pulse <= 1'b0;
            tmo_hold  <= 1'b0;
        end else begin
            tmo_pulse <= 1'b0;
            if (stall && (tmo_left == '0)) begin
                tmo_pulse <= 1'b1;
                tmo_hold  <= 1'b1;
                tmo_left  <= TMO_LOAD;
            end else if (slave_resp) begin
                tmo_left  <= TMO_LOAD;
            end else if (stall) begin
                tmo_left  <= tmo_left - 1'b1;
            end
        end
    end
`else
    assign tmo_pulse = 1'b0;
    assign tmo_hold  = 1'b0;
`endif

    // Read data is broadcast; only ack/err/rty are steered.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Outputs: request mux from the registered grant, responses routed back to the owner.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        case (state_q)
            GNT0: begin
                s_cyc_o  = m0_cyc_i & ~tmo_hold;
                s_stb_o  = m0_stb_i & ~tmo_hold;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i & ~tmo_hold;
                m0_err_o = (s_err_i & ~tmo_hold) | tmo_pulse;
                m0_rty_o = s_rty_i & ~tmo_hold;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i & ~tmo_hold;
                s_stb_o  = m1_stb_i & ~tmo_hold;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i & ~tmo_hold;
                m1_err_o = (s_err_i & ~tmo_hold) | tmo_pulse;
                m1_rty_o = s_rty_i & ~tmo_hold;
            end
            default: ;
        endcase
    end

endmodule
